// File: rtl/pc_sequencer.sv
// Program-counter controller for the fetch path: IDLE/RUN/DONE lifecycle,
// single-cycle branch resolution through the branch-target LUT, retired count.
module pc_sequencer #(
  parameter int D        = 10,
  parameter int START_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stall,
  input  logic             branch_en,
  input  logic             branch_cond,
  input  logic             branch_rel,
  input  logic [3:0]       branch_idx,
  input  logic             halt,
  output logic [3:0]       lut_addr,
  input  logic [D-1:0]     lut_target,
  output logic [D-1:0]     pc,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [D-1:0]     LP_START = D'(START_PC);
  localparam logic [D-1:0]     LP_PC1   = {{(D-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LP_CNT1  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic [D-1:0]     r_pc, w_pc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_taken;

  assign lut_addr = branch_idx;
  assign w_taken  = branch_en & branch_cond;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_pc    <= LP_START;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = LP_START;
          w_cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (r_cnt != '1) w_cnt_nxt = r_cnt + LP_CNT1;
          // halt holds pc even if a taken branch arrives in the same cycle
          if (halt)                   w_state_nxt = S_DONE;
          else if (w_taken && !branch_rel) w_pc_nxt = lut_target;
          else if (w_taken)           w_pc_nxt = r_pc + lut_target;
          else                        w_pc_nxt = r_pc + LP_PC1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    running   = (r_state == S_RUN);
    done      = (r_state == S_DONE);
    pc        = r_pc;
    instr_cnt = r_cnt;
  end

endmodule
